// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle for the EX-stage RV32M multiply/divide unit.
// master = ID/EX pipeline driver, slave = ex_muldiv_unit.
interface ex_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [2:0]       funct3_i;
  logic [WIDTH-1:0] op1_i;
  logic [WIDTH-1:0] op2_i;
  logic [4:0]       rd_i;
  logic             flush_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic [4:0]       rd_o;

  modport master (
    output start_i, funct3_i, op1_i, op2_i, rd_i, flush_i,
    input  stall_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, funct3_i, op1_i, op2_i, rd_i, flush_i,
    output stall_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine (shift-add / restoring divide) for the EX stage.
// Optional single-cycle multiplier: define MULDIV_FAST_MUL_EN.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  ex_muldiv_unit_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [4:0]       rd_q, rd_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       rd_out_q, rd_out_d;
  logic             stall_c;

  // Operand decode for the instruction sitting in ID/EX
  logic [2:0]       f3_in;
  logic             is_div, sgn1, sgn2, a_neg, b_neg, div_zero, div_ovf, special, neg_start;
  logic [WIDTH-1:0] mag1, mag2, special_res;

  always_comb begin
    f3_in     = bus.funct3_i;
    is_div    = f3_in[2];
    sgn1      = (f3_in == 3'd1) || (f3_in == 3'd2) || (f3_in == 3'd4) || (f3_in == 3'd6);
    sgn2      = (f3_in == 3'd1) || (f3_in == 3'd4) || (f3_in == 3'd6);
    a_neg     = sgn1 & bus.op1_i[WIDTH-1];
    b_neg     = sgn2 & bus.op2_i[WIDTH-1];
    mag1      = a_neg ? (~bus.op1_i + WIDTH'(1)) : bus.op1_i;
    mag2      = b_neg ? (~bus.op2_i + WIDTH'(1)) : bus.op2_i;
    div_zero  = (bus.op2_i == '0);
    div_ovf   = ((f3_in == 3'd4) || (f3_in == 3'd6)) && (bus.op1_i == MIN_NEG) && (bus.op2_i == '1);
    special   = is_div & (div_zero | div_ovf);
    // Remainder follows the dividend; everything else follows the sign product
    neg_start = (is_div && f3_in[1]) ? a_neg : (a_neg ^ b_neg);
    if (div_zero) special_res = f3_in[1] ? bus.op1_i : '1;
    else          special_res = f3_in[1] ? '0 : MIN_NEG;
  end

  // One iteration of the datapath, plus the finished result it implies
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [PW-1:0]    step_next, mul_full;
  logic [WIDTH-1:0] quo, rem, final_res;

  always_comb begin
    mul_sum   = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {prod_q[PW-1:WIDTH], prod_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mcand_q});
    if (f3_q[2]) begin
      step_next[PW-1:WIDTH] = div_ge ? WIDTH'(div_shift - {1'b0, mcand_q}) : div_shift[WIDTH-1:0];
      step_next[WIDTH-1:0]  = {prod_q[WIDTH-2:0], div_ge};
    end else begin
      step_next = {mul_sum, prod_q[WIDTH-1:1]};
    end
    mul_full = neg_q ? (~step_next + PW'(1)) : step_next;
    quo      = step_next[WIDTH-1:0];
    rem      = step_next[PW-1:WIDTH];
    case (f3_q)
      3'd0:          final_res = mul_full[WIDTH-1:0];
      3'd1, 3'd2,
      3'd3:          final_res = mul_full[PW-1:WIDTH];
      3'd4, 3'd5:    final_res = neg_q ? (~quo + WIDTH'(1)) : quo;
      default:       final_res = neg_q ? (~rem + WIDTH'(1)) : rem;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [PW-1:0]    fast_prod, fast_full;
  logic [WIDTH-1:0] fast_res;

  always_comb begin
    fast_prod = PW'(mag1) * PW'(mag2);
    fast_full = neg_start ? (~fast_prod + PW'(1)) : fast_prod;
    fast_res  = (f3_in[1:0] == 2'd0) ? fast_full[WIDTH-1:0] : fast_full[PW-1:WIDTH];
  end
`endif

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    done_d   = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;
    stall_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          stall_c = 1'b1;
          f3_d    = f3_in;
          rd_d    = bus.rd_i;
          neg_d   = neg_start;
          cnt_d   = '0;
          if (special) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = special_res;
            rd_out_d = bus.rd_i;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = fast_res;
            rd_out_d = bus.rd_i;
          end
`endif
          else begin
            state_d = S_CALC;
            mcand_d = mag2;
            prod_d  = {{WIDTH{1'b0}}, mag1};
          end
        end
      end
      S_CALC: begin
        stall_c = 1'b1;
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          prod_d = step_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = final_res;
            rd_out_d = rd_q;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign bus.stall_o  = stall_c;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (default iterative build).
module tb_ex_muldiv_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  ex_muldiv_unit_if #(.WIDTH(32)) bus ();

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.start_i  = 1'b0;
    bus.funct3_i = 3'd0;
    bus.op1_i    = '0;
    bus.op2_i    = '0;
    bus.rd_i     = '0;
    bus.flush_i  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL reset done_o: got %b want 0", bus.done_o); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_bad++; $display("FAIL reset stall_o: got %b want 0", bus.stall_o); end
    n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL reset result_o: got %h want 0", bus.result_o); end
    n_cmp++; if (bus.rd_o !== 5'd0) begin n_bad++; $display("FAIL reset rd_o: got %0d want 0", bus.rd_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one op for a single cycle and check latency, stall count, result, rd and pulse width
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                       input string name);
    int lat;
    int stalls;
    lat    = -1;
    stalls = 0;
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.funct3_i = f3;
    bus.op1_i    = a;
    bus.op2_i    = b;
    bus.rd_i     = rd;
    bus.flush_i  = 1'b0;
    #1;
    for (int c = 0; c < 100; c++) begin
      if (bus.done_o === 1'b1) begin lat = c; break; end
      if (bus.stall_o === 1'b1) stalls++;
      @(negedge clk);
      bus.start_i = 1'b0;
      #1;
    end
    bus.start_i = 1'b0;
    n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
    n_cmp++; if (stalls !== exp_lat) begin n_bad++; $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, exp_lat); end
    n_cmp++; if (bus.result_o !== exp_res) begin n_bad++; $display("FAIL %s result: got %h want %h", name, bus.result_o, exp_res); end
    n_cmp++; if (bus.rd_o !== rd) begin n_bad++; $display("FAIL %s rd: got %0d want %0d", name, bus.rd_o, rd); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_bad++; $display("FAIL %s stall in done: got %b want 0", name, bus.stall_o); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL %s done pulse width: got %b want 0", name, bus.done_o); end
    n_cmp++; if (bus.result_o !== exp_res) begin n_bad++; $display("FAIL %s result hold: got %h want %h", name, bus.result_o, exp_res); end
  endtask

  task automatic test_mul();
    issue(3'd0, 32'd7,        32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33, "mul_7_m3");
    issue(3'd0, 32'h1234_5678, 32'h10,       5'd2,  32'h2345_6780, 33, "mul_shift");
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 33, "mulhu_max");
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, 33, "mulh_m1");
    issue(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd7, 32'hFFFF_FFFF, 33, "mulhsu_m1_2");
  endtask

  task automatic test_div();
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8,  32'hFFFF_FFFD, 33, "div_m7_2");
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9,  32'hFFFF_FFFF, 33, "rem_m7_2");
    issue(3'd5, 32'd100,       32'd7, 5'd10, 32'd14,        33, "divu_100_7");
    issue(3'd7, 32'd100,       32'd7, 5'd11, 32'd2,         33, "remu_100_7");
  endtask

  task automatic test_special();
    issue(3'd5, 32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, 1, "divu_by0");
    issue(3'd6, 32'd5,         32'd0,         5'd13, 32'd5,         1, "rem_by0");
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1, "div_ovf");
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 1, "rem_ovf");
  endtask

  task automatic test_flush();
    logic        seen_done;
    logic [31:0] prev_res;
    seen_done = 1'b0;
    prev_res  = bus.result_o;
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.funct3_i = 3'd5;
    bus.op1_i    = 32'd1000;
    bus.op2_i    = 32'd3;
    bus.rd_i     = 5'd20;
    #1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.flush_i = (c == 10);
      #1;
      if (bus.done_o === 1'b1) seen_done = 1'b1;
    end
    n_cmp++; if (bus.stall_o !== 1'b1) begin n_bad++; $display("FAIL flush stall at flush cycle: got %b want 1", bus.stall_o); end
    n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL flush early done: got %b want 0", seen_done); end
    n_cmp++; if (bus.result_o !== prev_res) begin n_bad++; $display("FAIL flush result held: got %h want %h", bus.result_o, prev_res); end
    issue(3'd0, 32'd6, 32'd9, 5'd21, 32'd54, 33, "mul_after_flush");
    // Start and flush together in IDLE: nothing is accepted
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.flush_i  = 1'b1;
    bus.funct3_i = 3'd5;
    bus.op1_i    = 32'd9;
    bus.op2_i    = 32'd0;
    bus.rd_i     = 5'd22;
    #1;
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_bad++; $display("FAIL start+flush stall: got %b want 0", bus.stall_o); end
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL start+flush done: got %b want 0", bus.done_o); end
    n_cmp++; if (bus.rd_o !== 5'd21) begin n_bad++; $display("FAIL start+flush rd held: got %0d want 21", bus.rd_o); end
  endtask

  task automatic test_back_to_back();
    int lat1;
    int lat2;
    lat1 = -1;
    lat2 = -1;
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.flush_i  = 1'b0;
    bus.funct3_i = 3'd0;
    bus.op1_i    = 32'd3;
    bus.op2_i    = 32'd4;
    bus.rd_i     = 5'd5;
    #1;
    for (int c = 0; c < 120; c++) begin
      if (bus.done_o === 1'b1) begin
        if (lat1 < 0) begin
          lat1 = c;
          n_cmp++; if (bus.result_o !== 32'd12) begin n_bad++; $display("FAIL b2b first result: got %h want 0000000c", bus.result_o); end
          n_cmp++; if (bus.rd_o !== 5'd5) begin n_bad++; $display("FAIL b2b first rd: got %0d want 5", bus.rd_o); end
          n_cmp++; if (bus.stall_o !== 1'b0) begin n_bad++; $display("FAIL b2b done stall: got %b want 0", bus.stall_o); end
        end else begin
          lat2 = c;
          break;
        end
      end
      @(negedge clk);
      if (lat1 >= 0) begin
        bus.funct3_i = 3'd5;
        bus.op1_i    = 32'd100;
        bus.op2_i    = 32'd7;
        bus.rd_i     = 5'd6;
      end
      #1;
    end
    bus.start_i = 1'b0;
    n_cmp++; if (lat1 !== 33) begin n_bad++; $display("FAIL b2b first latency: got %0d want 33", lat1); end
    n_cmp++; if (lat2 !== 67) begin n_bad++; $display("FAIL b2b second latency: got %0d want 67", lat2); end
    n_cmp++; if (bus.result_o !== 32'd14) begin n_bad++; $display("FAIL b2b second result: got %h want 0000000e", bus.result_o); end
    n_cmp++; if (bus.rd_o !== 5'd6) begin n_bad++; $display("FAIL b2b second rd: got %0d want 6", bus.rd_o); end
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.funct3_i = 3'd0;
    bus.op1_i    = 32'd11;
    bus.op2_i    = 32'd13;
    bus.rd_i     = 5'd25;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (bus.stall_o !== 1'b1) begin n_bad++; $display("FAIL midcalc stall before reset: got %b want 1", bus.stall_o); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_bad++; $display("FAIL midcalc reset stall: got %b want 0", bus.stall_o); end
    n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL midcalc reset result: got %h want 0", bus.result_o); end
    n_cmp++; if (bus.rd_o !== 5'd0) begin n_bad++; $display("FAIL midcalc reset rd: got %0d want 0", bus.rd_o); end
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL midcalc reset done: got %b want 0", bus.done_o); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd7, 32'd50, 32'd8, 5'd26, 32'd2, 33, "remu_after_reset");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_mid_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
